// File: rtl/ioctl_load_ctrl.sv
`default_nettype none
// ioctl_load_ctrl: steers the HPS ioctl download stream to the ROM write port,
// the variant register and the DIP bank, and sequences the game-core reset.
module ioctl_load_ctrl #(
    parameter int ROM_AW      = 16,
    parameter int HOLD_CYCLES = 32,
    parameter int ACK_TIMEOUT = 63
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    input  logic              rst_req,
    output logic [ROM_AW-1:0] rom_addr,
    output logic [7:0]        rom_data,
    output logic              rom_wr,
    input  logic              rom_ack,
    output logic [7:0]        variant,
    output logic [7:0]        dip0,
    output logic [7:0]        dip1,
    output logic [7:0]        dip2,
    output logic              core_reset,
    output logic              rom_loaded,
    output logic              err_overrun,
    output logic              err_timeout
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ROM_WR = 1'b1;

    localparam logic [7:0] C_HOLD    = 8'(HOLD_CYCLES);
    localparam logic [7:0] C_TO_LAST = 8'(ACK_TIMEOUT - 1);

    logic [0:0]        r_state;
    logic [ROM_AW-1:0] r_rom_addr;
    logic [7:0]        r_rom_data;
    logic              r_rom_wr;
    logic [7:0]        r_to_cnt;
    logic              r_rom_loaded;
    logic              r_err_overrun;
    logic              r_err_timeout;
    logic              r_dl_q;
    logic [7:0]        r_hold_cnt;
    logic [7:0]        r_variant;
    logic [7:0]        r_dip0;
    logic [7:0]        r_dip1;
    logic [7:0]        r_dip2;

    logic w_idx_rom;
    logic w_in_range;
    logic w_rom_hit;
    logic w_rom_dl_start;
    logic w_rst_cond;
    logic w_strobe;

    assign w_idx_rom      = (ioctl_index == 8'd0);
    assign w_in_range     = ((ioctl_addr >> ROM_AW) == 25'd0);
    assign w_strobe       = ioctl_wr & ioctl_download;
    assign w_rom_hit      = w_strobe & w_idx_rom & w_in_range;
    assign w_rom_dl_start = ioctl_download & ~r_dl_q & w_idx_rom;
    assign w_rst_cond     = rst_req | (ioctl_download & w_idx_rom);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_rom_addr    <= '0;
            r_rom_data    <= 8'd0;
            r_rom_wr      <= 1'b0;
            r_to_cnt      <= 8'd0;
            r_rom_loaded  <= 1'b0;
            r_err_overrun <= 1'b0;
            r_err_timeout <= 1'b0;
            r_dl_q        <= 1'b0;
        end else begin
            r_dl_q <= ioctl_download;
            // A commit in the same cycle as a new download start wins over the clear
            if (w_rom_dl_start) begin
                r_rom_loaded <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_rom_hit) begin
                        r_rom_addr <= ioctl_addr[ROM_AW-1:0];
                        r_rom_data <= ioctl_dout;
                        r_rom_wr   <= 1'b1;
                        r_to_cnt   <= 8'd0;
                        r_state    <= ST_ROM_WR;
                    end
                end
                ST_ROM_WR: begin
                    if (w_rom_hit) begin
                        r_err_overrun <= 1'b1;
                    end
                    if (rom_ack) begin
                        r_rom_wr     <= 1'b0;
                        r_rom_loaded <= 1'b1;
                        r_state      <= ST_IDLE;
                    end else if (r_to_cnt == C_TO_LAST) begin
                        r_rom_wr      <= 1'b0;
                        r_err_timeout <= 1'b1;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 8'd1;
                    end
                end
                default: begin
                    r_rom_wr <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    // Coming out of reset counts as a released reset request, so the stretch starts loaded
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_cnt <= C_HOLD;
        end else if (w_rst_cond) begin
            r_hold_cnt <= C_HOLD;
        end else if (r_hold_cnt != 8'd0) begin
            r_hold_cnt <= r_hold_cnt - 8'd1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_variant <= 8'd0;
            r_dip0    <= 8'd0;
            r_dip1    <= 8'd0;
            r_dip2    <= 8'd0;
        end else if (w_strobe) begin
            if (ioctl_index == 8'd1) begin
                r_variant <= ioctl_dout;
            end
            if (ioctl_index == 8'd254) begin
                case (ioctl_addr)
                    25'd0:   r_dip0 <= ioctl_dout;
                    25'd1:   r_dip1 <= ioctl_dout;
                    25'd2:   r_dip2 <= ioctl_dout;
                    default: ;
                endcase
            end
        end
    end

    assign ioctl_wait  = r_rom_wr;
    assign rom_wr      = r_rom_wr;
    assign rom_addr    = r_rom_addr;
    assign rom_data    = r_rom_data;
    assign variant     = r_variant;
    assign dip0        = r_dip0;
    assign dip1        = r_dip1;
    assign dip2        = r_dip2;
    assign core_reset  = w_rst_cond | (r_hold_cnt != 8'd0);
    assign rom_loaded  = r_rom_loaded;
    assign err_overrun = r_err_overrun;
    assign err_timeout = r_err_timeout;

endmodule
`default_nettype wire
